// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in / serial-out frame transmitter.
// Frame on tx: start bit (0), WIDTH data bits LSB-first, optional even parity
// bit, stop bit (1); every bit held BIT_CYCLES enabled cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the parity bit.
// en=0 freezes all state; rst is asynchronous active-low.
module serial_word_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   shift_d;
  logic               tx_q;
  logic               done_q;
  logic               bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic               parity_q;
`endif

  // Bit boundary detection and next shift-register value
  assign bit_end = (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign shift_d = shift_q >> 1;

  assign in_ready = en && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // Frame sequencer: state, bit timing, shift register and registered tx/done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (en) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (in_valid) begin
            shift_q  <= in_data;
            state_q  <= START;
            tx_q     <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^in_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_W'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed scenarios plus random traffic, checked
// cycle by cycle against a queue of expected line levels built per frame.
module tb_serial_word_tx;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned BIT_CYCLES = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 3;
`else
  localparam int unsigned NBITS = WIDTH + 2;
`endif
  localparam int unsigned FRAME = NBITS * BIT_CYCLES;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic             done;

  serial_word_tx #(.WIDTH(WIDTH), .BIT_CYCLES(BIT_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: remaining line levels of the current frame, one per enabled cycle
  bit q[$];
  bit tx_m   = 1'b1;
  bit busy_m = 1'b0;
  bit done_m = 1'b0;
  int n_done_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Expand a word into its full frame of per-cycle line levels
  function automatic void model_accept(input logic [WIDTH-1:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < int'(BIT_CYCLES); c++) q.push_back(bits[i]);
  endfunction

  // One clock: drive inputs after negedge, advance model on posedge, check at next negedge
  task automatic step(input bit e, input bit v, input logic [WIDTH-1:0] d);
    en = e; in_valid = v; in_data = d;
    #1;
    check("in_ready", in_ready, e && !busy_m);
    @(posedge clk);
    if (e) begin
      done_m = 1'b0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          done_m = 1'b1;
          n_done_m++;
        end
      end else if (v) begin
        model_accept(d);
      end
    end
    tx_m   = (q.size() > 0) ? q[0] : 1'b1;
    busy_m = (q.size() > 0);
    @(negedge clk);
    check("tx", tx, tx_m);
    check("busy", busy, busy_m);
    check("done", done, done_m);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    q.delete();
    tx_m = 1'b1; busy_m = 1'b0; done_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int  bc, dc;
  bit  prev_done;

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b1;
    repeat (6) step(1'b1, 1'b0, '0);

    // Single 0xA5 frame with an ignored 0xFF offered 10 cycles in
    bc = 0; dc = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step(1'b1, (i == 0) || (i == 10), (i == 0) ? 8'hA5 : 8'hFF);
      if (busy) bc++;
      if (done) dc++;
    end
    check("frame_len", bc, FRAME);
    check("done_pulses", dc, 1);

    // Enable stall of 5 cycles during data bit 3
    bc = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step(!(i >= 18 && i < 23), i == 0, 8'hA5);
      if (busy) bc++;
    end
    check("stall_len", bc, FRAME + 5);

    // Reset during data bit 5, then a clean 0x3C frame
    for (int i = 0; i < 26; i++) step(1'b1, i == 0, 8'h5A);
    do_reset();
    bc = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      step(1'b1, i == 0, 8'h3C);
      if (busy) bc++;
    end
    check("post_rst_len", bc, FRAME);

    // Back-to-back: in_valid held, 0x07 then 0x80; restart right after done
    n_done_m = 0; prev_done = 1'b0;
    for (int i = 0; i < 3 * FRAME && n_done_m < 2; i++) begin
      step(1'b1, 1'b1, (n_done_m == 0) ? 8'h07 : 8'h80);
      if (prev_done && n_done_m == 1) check("b2b_restart", busy, 1);
      prev_done = done;
    end
    check("b2b_frames", n_done_m, 2);
    repeat (4) step(1'b1, 1'b0, '0);

    // Random traffic with occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, WIDTH'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
